// File: rtl/calc_seq_core_if.sv
`default_nettype none
// ============================================================================
// Module   : calc_seq_core_if
// Brief    : Request/response bundle between operand capture and calc_seq_core.
// Revision : 1.0 - initial release
// ============================================================================
interface calc_seq_core_if #(
  parameter int WIDTH = 6
);
  logic                 start;
  logic [1:0]           op;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;
  logic [WIDTH-1:0]     rem;
  logic                 err;

  modport master (
    output start, op, a, b,
    input  busy, done, result, rem, err
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, rem, err
  );
endinterface
`default_nettype wire

// File: rtl/calc_seq_core.sv
`default_nettype none
// ============================================================================
// Module   : calc_seq_core
// Brief    : Shared add/sub/mul/div core; mul is shift-add, div is restoring.
// Revision : 1.0 - initial release
// ============================================================================
module calc_seq_core #(
  parameter int WIDTH = 6
) (
  input  logic              clk,
  input  logic              rst,
  calc_seq_core_if.slave    bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_run  = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  localparam logic [1:0] c_op_add = 2'b00;
  localparam logic [1:0] c_op_sub = 2'b01;
  localparam logic [1:0] c_op_mul = 2'b10;

  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

  logic [1:0]           r_state;
  logic [CW-1:0]        r_count;
  logic [1:0]           r_op;
  logic [WIDTH-1:0]     r_b;

  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;

  logic [WIDTH-1:0]     r_part;
  logic [WIDTH-1:0]     r_quot;

  logic [2*WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]     r_rem;
  logic                 r_err;

  logic                 w_accept;
  logic                 w_b_zero;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH-1:0]     w_diff;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic [WIDTH:0]       w_trial;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_part_next;
  logic [WIDTH-1:0]     w_quot_next;

  assign w_accept = bus.start && ((r_state == c_idle) || (r_state == c_done));
  assign w_b_zero = (bus.b == '0);
  assign w_sum    = {1'b0, bus.a} + {1'b0, bus.b};
  assign w_diff   = bus.a - bus.b;

  // One shift-add step: multiplier consumed LSB-first, multiplicand shifts up.
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  // When the subtraction is taken the true difference is below b, so the
  // low WIDTH bits alone hold it exactly.
  assign w_trial     = {r_part, r_quot[WIDTH-1]};
  assign w_ge        = (w_trial >= {1'b0, r_b});
  assign w_part_next = w_ge ? (w_trial[WIDTH-1:0] - r_b) : w_trial[WIDTH-1:0];
  assign w_quot_next = {r_quot[WIDTH-2:0], w_ge};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= c_idle;
      r_count  <= '0;
      r_op     <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_part   <= '0;
      r_quot   <= '0;
      r_result <= '0;
      r_rem    <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        c_idle, c_done: begin
          if (w_accept) begin
            r_op <= bus.op;
            r_b  <= bus.b;
            if (bus.op == c_op_add) begin
              r_result <= {{(WIDTH-1){1'b0}}, w_sum};
              r_rem    <= '0;
              r_err    <= w_sum[WIDTH];
              r_state  <= c_done;
            end else if (bus.op == c_op_sub) begin
              r_result <= {{WIDTH{1'b0}}, w_diff};
              r_rem    <= '0;
              r_err    <= (bus.a < bus.b);
              r_state  <= c_done;
            end else if (bus.op != c_op_mul && w_b_zero) begin
              r_result <= {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
              r_rem    <= bus.a;
              r_err    <= 1'b1;
              r_state  <= c_done;
            end else begin
              r_acc    <= '0;
              r_mcand  <= {{WIDTH{1'b0}}, bus.a};
              r_mplier <= bus.b;
              r_part   <= '0;
              r_quot   <= bus.a;
              r_count  <= '0;
              r_state  <= c_run;
            end
          end else begin
            r_state <= c_idle;
          end
        end

        c_run: begin
          if (r_op == c_op_mul) begin
            r_acc    <= w_acc_next;
            r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
          end else begin
            r_part <= w_part_next;
            r_quot <= w_quot_next;
          end

          if (r_count == c_last) begin
            r_count <= '0;
            r_state <= c_done;
            if (r_op == c_op_mul) begin
              r_result <= w_acc_next;
              r_rem    <= '0;
            end else begin
              r_result <= {{WIDTH{1'b0}}, w_quot_next};
              r_rem    <= w_part_next;
            end
            r_err <= 1'b0;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end

        default: begin
          r_state <= c_idle;
          r_count <= '0;
        end
      endcase
    end
  end

  assign bus.busy   = (r_state == c_run);
  assign bus.done   = (r_state == c_done);
  assign bus.result = r_result;
  assign bus.rem    = r_rem;
  assign bus.err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_calc_seq_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_seq_core
// Brief    : Directed self-checking bench for calc_seq_core at WIDTH=6.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_seq_core;

  localparam int WIDTH = 6;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  calc_seq_core_if #(.WIDTH(WIDTH)) bus ();

  calc_seq_core #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Launch one op, scramble operands after the accepting edge, wait for done.
  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [5:0] x, input logic [5:0] y,
                        input int exp_lat, input int exp_busy,
                        input logic [11:0] exp_res, input logic [5:0] exp_rem,
                        input logic exp_err);
    int          k;
    int          nb;
    logic        hold_ok;
    logic [11:0] prev;
    prev      = bus.result;
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    tick();
    bus.start = 1'b0;
    bus.a     = ~x;
    bus.b     = ~y;
    bus.op    = ~o;
    k       = 1;
    nb      = 0;
    hold_ok = 1'b1;
    while (!bus.done && k < 40) begin
      if (bus.busy) nb++;
      if (bus.result !== prev) hold_ok = 1'b0;
      tick();
      k++;
    end
    chk({tag, "_latency"}, k, exp_lat);
    chk({tag, "_busy_cycles"}, nb, exp_busy);
    chk({tag, "_result"}, {20'd0, bus.result}, {20'd0, exp_res});
    chk({tag, "_rem"}, {26'd0, bus.rem}, {26'd0, exp_rem});
    chk({tag, "_err"}, {31'd0, bus.err}, {31'd0, exp_err});
    chk({tag, "_hold_during_run"}, {31'd0, hold_ok}, 32'd1);
    tick();
    chk({tag, "_done_pulse_end"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    int   k;
    logic seen_done;
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    tick();
    tick();
    chk("rst_busy",   {31'd0, bus.busy}, 32'd0);
    chk("rst_done",   {31'd0, bus.done}, 32'd0);
    chk("rst_result", {20'd0, bus.result}, 32'd0);
    chk("rst_rem",    {26'd0, bus.rem}, 32'd0);
    chk("rst_err",    {31'd0, bus.err}, 32'd0);
    rst = 1'b0;
    tick();

    run_op("add_carry", 2'b00, 6'd40, 6'd30, 1, 0, 12'd70,   6'd0, 1'b1);
    run_op("add_plain", 2'b00, 6'd20, 6'd22, 1, 0, 12'd42,   6'd0, 1'b0);
    run_op("sub_borrow",2'b01, 6'd10, 6'd20, 1, 0, 12'd54,   6'd0, 1'b1);
    run_op("sub_plain", 2'b01, 6'd20, 6'd10, 1, 0, 12'd10,   6'd0, 1'b0);
    run_op("mul_max",   2'b10, 6'd63, 6'd63, 7, 6, 12'd3969, 6'd0, 1'b0);
    run_op("mul_zero",  2'b10, 6'd0,  6'd45, 7, 6, 12'd0,    6'd0, 1'b0);
    run_op("div_45_7",  2'b11, 6'd45, 6'd7,  7, 6, 12'd6,    6'd3, 1'b0);
    run_op("div_by_0",  2'b11, 6'd5,  6'd0,  1, 0, 12'd63,   6'd5, 1'b1);
    run_op("div_a_lt_b",2'b11, 6'd3,  6'd10, 7, 6, 12'd0,    6'd3, 1'b0);
    run_op("div_max_1", 2'b11, 6'd63, 6'd1,  7, 6, 12'd63,   6'd0, 1'b0);

    // Start pulses during RUN must not disturb the multiply in flight.
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.a     = 6'd7;
    bus.b     = 6'd9;
    tick();
    bus.op = 2'b00;
    bus.a  = 6'd1;
    bus.b  = 6'd1;
    k = 1;
    while (!bus.done && k < 40) begin
      bus.start = (k == 2 || k == 4);
      tick();
      k++;
    end
    bus.start = 1'b0;
    chk("hs_latency", k, 32'd7);
    chk("hs_result", {20'd0, bus.result}, 32'd63);
    chk("hs_err", {31'd0, bus.err}, 32'd0);

    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.a     = 6'd3;
    bus.b     = 6'd4;
    tick();
    bus.start = 1'b0;
    chk("b2b_done", {31'd0, bus.done}, 32'd1);
    chk("b2b_result", {20'd0, bus.result}, 32'd7);
    chk("b2b_err", {31'd0, bus.err}, 32'd0);
    tick();
    chk("b2b_done_end", {31'd0, bus.done}, 32'd0);

    // Reset in the middle of a divide discards it entirely.
    bus.start = 1'b1;
    bus.op    = 2'b11;
    bus.a     = 6'd60;
    bus.b     = 6'd7;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk("mid_busy_before_rst", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy",   {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_done",   {31'd0, bus.done}, 32'd0);
    chk("mid_rst_result", {20'd0, bus.result}, 32'd0);
    chk("mid_rst_rem",    {26'd0, bus.rem}, 32'd0);
    chk("mid_rst_err",    {31'd0, bus.err}, 32'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done || bus.busy) seen_done = 1'b1;
    end
    chk("mid_rst_no_done", {31'd0, seen_done}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
